// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared types and constants for the I2S audio transmitter.
//   SAMPLE_W       bits per channel sample (two's complement, <= 31)
//   FRAME_BITS     sclk periods per stereo I2S frame (two 32-bit slots)
//   BIT_W          width of the in-frame bit counter
//   LEFT_MSB_POS   bit position of the left-sample MSB within a frame
//   RIGHT_MSB_POS  bit position of the right-sample MSB within a frame
//   stereo_sample_t  one buffered {left, right} pair
//   frame_bit()    serial data bit for a given frame position
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int SAMPLE_W      = 16;
    localparam int FRAME_BITS    = 64;
    localparam int BIT_W         = $clog2(FRAME_BITS);
    // Philips format: the MSB follows each lrclk edge by one bit clock.
    localparam int LEFT_MSB_POS  = 1;
    localparam int RIGHT_MSB_POS = 33;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_sample_t;

    // Bit shown on sda at frame position pos; positions outside the two
    // sample windows carry zero padding.
    function automatic logic frame_bit(stereo_sample_t f, logic [BIT_W-1:0] pos);
        int                  p;
        logic [SAMPLE_W-1:0] sh;
        p         = int'(pos);
        sh        = '0;
        frame_bit = 1'b0;
        if (p >= LEFT_MSB_POS && p < LEFT_MSB_POS + SAMPLE_W) begin
            sh        = f.left >> (SAMPLE_W - 1 - (p - LEFT_MSB_POS));
            frame_bit = sh[0];
        end else if (p >= RIGHT_MSB_POS && p < RIGHT_MSB_POS + SAMPLE_W) begin
            sh        = f.right >> (SAMPLE_W - 1 - (p - RIGHT_MSB_POS));
            frame_bit = sh[0];
        end
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// -----------------------------------------------------------------------------
// audio_sample_fifo
// Single-clock FIFO of stereo sample pairs. Pushes while full and pops while
// empty are ignored, so a pop on an empty FIFO never disturbs a same-cycle push.
//   clk, rst_n  clock and asynchronous active-low reset
//   push        write request; wr_data is stored when not full
//   wr_data     sample pair to store
//   pop         read request; head advances when not empty
//   rd_data     current head entry (valid when !empty)
//   full/empty  occupancy flags
//   level       current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  stereo_sample_t           wr_data,
    input  logic                     pop,
    output stereo_sample_t           rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    stereo_sample_t mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; the pointers and level define
    // which entries are meaningful, and a reset-free array maps onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// -----------------------------------------------------------------------------
// audio_i2s_tx
// Buffers stereo PCM samples and serialises one frame per I2S period in
// Philips format (32-bit slots, MSB first, one-bit delay after lrclk edges).
//   audio_clk   audio domain clock
//   rst_n       asynchronous active-low reset
//   in_valid    sample pair offered; accepted when in_ready is high
//   in_ready    FIFO can accept (not full)
//   in_left     left sample, two's complement
//   in_right    right sample, two's complement
//   mute        zeroes the frame loaded at the next frame start
//   fifo_level  current FIFO occupancy
//   underflow   one-cycle pulse when a frame starts with the FIFO empty
//   i2s_sclk    bit clock
//   i2s_lrclk   word select, 0 = left, 1 = right
//   i2s_sda     serial data, changes on sclk falling edges
// -----------------------------------------------------------------------------
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int SCLK_HALF  = 2
) (
    input  logic                          audio_clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SAMPLE_W-1:0]           in_left,
    input  logic [SAMPLE_W-1:0]           in_right,
    input  logic                          mute,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow,
    output logic                          i2s_sclk,
    output logic                          i2s_lrclk,
    output logic                          i2s_sda
);

    localparam int CNT_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

    logic [CNT_W-1:0] div_cnt;
    logic [BIT_W-1:0] bitcnt;
    logic [BIT_W-1:0] bitcnt_next;
    stereo_sample_t   frame;
    stereo_sample_t   frame_next;
    stereo_sample_t   fifo_head;
    stereo_sample_t   wr_sample;
    logic             half_done;
    logic             fall;
    logic             frame_start;
    logic             fifo_full;
    logic             fifo_empty;

    assign wr_sample   = '{left: in_left, right: in_right};
    assign in_ready    = !fifo_full;
    assign half_done   = (div_cnt == CNT_W'(SCLK_HALF - 1));
    assign fall        = half_done && i2s_sclk;
    assign bitcnt_next = bitcnt + 1'b1;
    // The fall that wraps the bit counter to 0 begins a new frame.
    assign frame_start = fall && (bitcnt == BIT_W'(FRAME_BITS - 1));

    audio_sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (audio_clk),
        .rst_n   (rst_n),
        .push    (in_valid),
        .wr_data (wr_sample),
        .pop     (frame_start),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        frame_next = frame;
        if (frame_start) begin
            // The head is still popped while muted; only the data is dropped.
            frame_next = (fifo_empty || mute) ? '0 : fifo_head;
        end
    end

    always_ff @(posedge audio_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            bitcnt    <= '1;
            frame     <= '0;
            i2s_sclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
            i2s_sda   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            div_cnt   <= half_done ? '0 : div_cnt + 1'b1;
            underflow <= frame_start && fifo_empty;
            if (half_done) begin
                i2s_sclk <= !i2s_sclk;
            end
            if (fall) begin
                bitcnt    <= bitcnt_next;
                frame     <= frame_next;
                i2s_lrclk <= bitcnt_next[BIT_W-1];
                // Position 0 lies outside both sample windows, so the freshly
                // loaded frame never leaks onto sda at the frame start.
                i2s_sda   <= frame_bit(frame_next, bitcnt_next);
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_audio_i2s_tx
// Directed testbench for audio_i2s_tx (SCLK_HALF = 2, FIFO_DEPTH = 8).
// Cycle numbers count audio_clk rising edges after reset release.
// -----------------------------------------------------------------------------
module tb_audio_i2s_tx;

    localparam int SCLK_HALF = 2;
    localparam logic [63:0] LR_EXP = 64'hFFFF_FFFF_0000_0000;

    logic        audio_clk = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        mute      = 1'b0;
    logic [15:0] in_left   = '0;
    logic [15:0] in_right  = '0;
    logic        in_ready;
    logic [3:0]  fifo_level;
    logic        underflow;
    logic        i2s_sclk;
    logic        i2s_lrclk;
    logic        i2s_sda;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    logic prev_sclk    = 1'b0;
    logic last_lr      = 1'b1;
    logic fall         = 1'b0;
    logic is_start     = 1'b0;

    audio_i2s_tx #(
        .FIFO_DEPTH (8),
        .SCLK_HALF  (SCLK_HALF)
    ) dut (
        .audio_clk  (audio_clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_left    (in_left),
        .in_right   (in_right),
        .mute       (mute),
        .fifo_level (fifo_level),
        .underflow  (underflow),
        .i2s_sclk   (i2s_sclk),
        .i2s_lrclk  (i2s_lrclk),
        .i2s_sda    (i2s_sda)
    );

    always #5 audio_clk = ~audio_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and sample 1 ns after the edge; a frame start is an
    // sclk fall where lrclk goes from right (1) to left (0).
    task automatic tick();
        @(posedge audio_clk);
        #1;
        cyc++;
        fall     = prev_sclk && !i2s_sclk;
        is_start = fall && !i2s_lrclk && last_lr;
        if (fall) last_lr = i2s_lrclk;
        prev_sclk = i2s_sclk;
    endtask

    task automatic release_reset();
        rst_n     = 1'b1;
        cyc       = 0;
        prev_sclk = 1'b0;
        last_lr   = 1'b1;
        fall      = 1'b0;
        is_start  = 1'b0;
    endtask

    task automatic push_sample(input logic [15:0] l, input logic [15:0] r);
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            tick();
            found = is_start;
        end
        check({tag, "_start_seen"}, 64'(found), 64'(1));
    endtask

    // Collect bit positions 1..63 after a frame start (position 0 is the
    // sample at the start itself).
    task automatic capture_body(output logic [63:0] bits, output logic [63:0] lr);
        bits = 64'(i2s_sda);
        lr   = 64'(i2s_lrclk);
        for (int n = 1; n < 64; n++) begin
            int w;
            w = 0;
            do begin
                tick();
                w++;
            end while (!fall && w < 20);
            if (!fall) check("fall_timeout", 64'(fall), 64'(1));
            bits = bits | (64'(i2s_sda) << n);
            lr   = lr | (64'(i2s_lrclk) << n);
        end
    endtask

    task automatic capture_frame(input string tag, output logic [63:0] bits,
                                 output logic [63:0] lr, output logic uf,
                                 output logic [3:0] lvl);
        wait_start(tag);
        uf  = underflow;
        lvl = fifo_level;
        capture_body(bits, lr);
    endtask

    // Expected sda pattern of a frame, indexed by bit position.
    function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
        logic [15:0] t;
        exp_frame = '0;
        for (int n = 0; n < 16; n++) begin
            t = l >> (15 - n);
            exp_frame = exp_frame | (64'(t[0]) << (1 + n));
            t = r >> (15 - n);
            exp_frame = exp_frame | (64'(t[0]) << (33 + n));
        end
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] bits;
        logic [63:0] lr;
        logic        uf;
        logic [3:0]  lvl;
        int          uf_bad;
        int          lr_bad;
        int          sda_bad;
        logic        uf_e;
        logic        lr_e;

        // Reset state
        repeat (3) @(posedge audio_clk);
        #1;
        check("reset_outs", 64'({i2s_sclk, i2s_lrclk, i2s_sda, underflow}), 64'(0));
        check("reset_level", 64'(fifo_level), 64'(0));
        check("reset_ready", 64'(in_ready), 64'(1));
        release_reset();

        // 1: idle timing
        tick();
        check("t1_sclk_c1", 64'(i2s_sclk), 64'(0));
        tick();
        check("t1_rise_c2", 64'(i2s_sclk), 64'(1));
        tick();
        tick();
        check("t1_fall_c4", 64'({i2s_sclk, underflow}), 64'(2'b01));
        uf_bad  = 0;
        lr_bad  = 0;
        sda_bad = 0;
        while (cyc < 516) begin
            tick();
            uf_e = ((cyc - 4) % 256 == 0);
            lr_e = (((cyc - 4) / 4) % 64 >= 32);
            if (underflow !== uf_e) uf_bad++;
            if (i2s_lrclk !== lr_e) lr_bad++;
            if (i2s_sda !== 1'b0)   sda_bad++;
        end
        check("t1_underflow_period", 64'(uf_bad), 64'(0));
        check("t1_lrclk_period", 64'(lr_bad), 64'(0));
        check("t1_sda_silent", 64'(sda_bad), 64'(0));

        // 2: single sample, hand-computed frame
        check("t2_ready", 64'(in_ready), 64'(1));
        push_sample(16'h8001, 16'h7FFE);
        check("t2_level_in", 64'(fifo_level), 64'(1));
        capture_frame("t2", bits, lr, uf, lvl);
        check("t2_bits", bits, 64'h0000_FFFC_0001_0002);
        check("t2_lrclk", lr, LR_EXP);
        check("t2_underflow", 64'(uf), 64'(0));
        check("t2_level_out", 64'(lvl), 64'(0));

        // 3: fill the FIFO, then drain in order
        wait_start("t3_align");
        for (int i = 0; i < 10; i++) begin
            check("t3_ready", 64'(in_ready), 64'(i < 8));
            in_valid = 1'b1;
            in_left  = 16'h1100 + 16'(i);
            in_right = 16'h2200 + 16'(i);
            tick();
        end
        in_valid = 1'b0;
        check("t3_level_full", 64'(fifo_level), 64'(8));
        check("t3_ready_full", 64'(in_ready), 64'(0));
        for (int k = 0; k < 8; k++) begin
            capture_frame("t3", bits, lr, uf, lvl);
            check("t3_bits", bits, exp_frame(16'h1100 + 16'(k), 16'h2200 + 16'(k)));
            check("t3_underflow", 64'(uf), 64'(0));
            check("t3_level", 64'(lvl), 64'(7 - k));
        end
        capture_frame("t3_empty", bits, lr, uf, lvl);
        check("t3_empty_uf", 64'(uf), 64'(1));
        check("t3_empty_bits", bits, 64'(0));

        // 4: write on the frame-start cycle of an empty FIFO
        repeat (3) tick();
        in_valid = 1'b1;
        in_left  = 16'hA5C3;
        in_right = 16'h0F0F;
        tick();
        in_valid = 1'b0;
        check("t4_start", 64'({is_start, underflow}), 64'(2'b11));
        check("t4_level", 64'(fifo_level), 64'(1));
        capture_body(bits, lr);
        check("t4_silent", bits, 64'(0));
        capture_frame("t4_next", bits, lr, uf, lvl);
        check("t4_bits", bits, exp_frame(16'hA5C3, 16'h0F0F));
        check("t4_next_uf", 64'(uf), 64'(0));
        check("t4_next_level", 64'(lvl), 64'(0));

        // 5: mute drains queued samples as silence
        mute = 1'b1;
        push_sample(16'hFFFF, 16'hFFFF);
        push_sample(16'h1234, 16'h4321);
        check("t5_level_in", 64'(fifo_level), 64'(2));
        capture_frame("t5_a", bits, lr, uf, lvl);
        check("t5_a", 64'({bits, uf, lvl}), 64'({64'(0), 1'b0, 4'd1}));
        capture_frame("t5_b", bits, lr, uf, lvl);
        check("t5_b", 64'({bits, uf, lvl}), 64'({64'(0), 1'b0, 4'd0}));
        mute = 1'b0;
        capture_frame("t5_c", bits, lr, uf, lvl);
        check("t5_c_uf", 64'(uf), 64'(1));

        // 6: asynchronous reset mid-frame with entries queued
        repeat (10) tick();
        push_sample(16'h0001, 16'h0002);
        push_sample(16'h0003, 16'h0004);
        push_sample(16'h0005, 16'h0006);
        check("t6_level_in", 64'(fifo_level), 64'(3));
        for (int i = 0; i < 8 && !i2s_sclk; i++) tick();
        check("t6_sclk_high", 64'(i2s_sclk), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_outs", 64'({i2s_sclk, i2s_lrclk, i2s_sda, underflow}), 64'(0));
        check("t6_async_level", 64'(fifo_level), 64'(0));
        check("t6_async_ready", 64'(in_ready), 64'(1));
        repeat (2) @(posedge audio_clk);
        #1;
        release_reset();
        tick();
        check("t6_sclk_c1", 64'(i2s_sclk), 64'(0));
        tick();
        check("t6_rise_c2", 64'(i2s_sclk), 64'(1));
        tick();
        tick();
        check("t6_fall_c4", 64'({i2s_sclk, underflow}), 64'(2'b01));
        check("t6_level", 64'(fifo_level), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
